code_entry_ctrl: RTL
====================

// Module: code_entry_ctrl
// PURPOSE
//  Player-side game controller: debounces start/enter buttons, latches a pseudo-random secret,
//  collects NUM_DIGITS switch-entered digits per guess, checks each guess and produces
//  startgame/breakcode for the colour-LED driver plus a per-guess hit count and a lose flag.
//  Sits between board buttons/switches and the LED driver.
// PARAMETERS
//  NUM_DIGITS      4      digits per code; NUM_DIGITS*DIGIT_W must equal 16 (LFSR width)
//  DIGIT_W         4      bits per digit (one switch group)
//  MAX_TRIES       8      wrong guesses allowed before LOSE (>=1)
//  DEBOUNCE_CYCLES 500000 consecutive stable cycles for a button level change (5 ms @100 MHz)
//  LFSR_SEED       16'hACE1  nonzero reset value of the secret LFSR
// PORTS
//  clk        in   1                  system clock (100 MHz)
//  reset      in   1                  asynchronous, active-high reset
//  btn_start  in   1                  raw start button, asynchronous to clk
//  btn_enter  in   1                  raw enter button, asynchronous to clk
//  sw_digit   in   DIGIT_W            raw switch value of current digit
//  startgame  out  1                  game active (ENTER/CHECK/WIN/LOSE)
//  breakcode  out  1                  code broken (WIN)
//  lose       out  1                  tries exhausted (LOSE)
//  hits       out  $clog2(NUM_DIGITS+1)  digits in correct position in last checked guess
//  tries      out  $clog2(MAX_TRIES+1)   wrong guesses so far
//  secret     out  NUM_DIGITS*DIGIT_W    current secret (bench/debug visibility)
// BEHAVIOUR
//  - Reset: state=IDLE, startgame=0, breakcode=0, lose=0, hits=0, tries=0, secret=0,
//    LFSR=LFSR_SEED, digit index=0, debounce counters/stable levels=0.
//  - Inputs: btn_start, btn_enter, sw_digit each pass a 2-flop synchroniser. Each button then a
//    debouncer: stable level updates only after DEBOUNCE_CYCLES consecutive cycles of differing
//    synced input; any mismatch-free break restarts count. Rising edge of stable level = 1-cycle
//    press pulse. Raw press -> pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, steps every cycle, never reset by start.
//  - FSM IDLE->ENTER on start pulse: secret<=LFSR value that cycle, tries<=0, hits<=0, idx<=0.
//  - ENTER: enter pulse stores synced sw_digit into guess slot idx (slot 0 = MS digit), idx++.
//    Pulse storing slot NUM_DIGITS-1 -> CHECK next cycle, idx<=0.
//  - CHECK (exactly 1 cycle): hits<=count of slots equal to secret slot.
//    hits==NUM_DIGITS -> WIN; else tries++ and (tries+1==MAX_TRIES ? LOSE : ENTER).
//  - WIN: breakcode=1, lose=0. LOSE: lose=1, breakcode=0. Both hold until start pulse or reset.
//  - startgame=1 in ENTER, CHECK, WIN, LOSE; 0 only in IDLE. All outputs registered.
//  - Start pulse in ANY state (incl. mid-entry, CHECK, WIN, LOSE) restarts: same actions as
//    IDLE->ENTER, breakcode/lose cleared, partial guess discarded. Start wins over simultaneous enter.
//  - Enter pulses in IDLE, CHECK, WIN, LOSE ignored. Button held: one pulse only.
//  - tries saturates at MAX_TRIES; hits keeps last checked value until next CHECK or restart.
// STRUCTURE
//  - Package game_pkg: state enum {IDLE, ENTER, CHECK, WIN, LOSE}, LFSR width/taps constant.
//  - Sub-module btn_debounce (param DEBOUNCE_CYCLES): sync + debounce + rising-edge pulse;
//    instantiated twice. FSM, LFSR, guess register and comparator in code_entry_ctrl.
// TESTING (DEBOUNCE_CYCLES=4, MAX_TRIES=3; read secret after start)
//  - Reset mid-game -> next cycle all outputs 0, state IDLE; LFSR resumes from 16'hACE1.
//  - Start press: btn_start glitch 3 cycles -> no pulse; held 10 cycles -> startgame=1 after 2+4+1
//    cycles, secret nonzero, tries=0.
//  - Enter the 4 secret digits (e.g. secret 16'h3A5C: 3,A,5,C) -> CHECK, hits=4, breakcode=1,
//    lose=0; startgame stays 1; LED driver sees green path.
//  - Guess with 2 matching positions -> hits=2, tries=1, back to ENTER; 3 wrong guesses -> lose=1, tries=3.
//  - Start pressed after 2 digits entered -> guess discarded, new secret, next 4 digits form a full guess.
//  - Enter and start pulses same cycle in ENTER -> restart, digit not stored; enter in WIN -> ignored.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encoding and LFSR constants for the code-entry game
package game_pkg;
  typedef enum logic [2:0] {IDLE, ENTER, CHECK, WIN, LOSE} state_t;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, debounces it and emits a one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic stable;
  logic [CW-1:0] cnt;
  logic done;
  assign done = (sync[1] != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // accept a new level only after it has differed from the stable one for a full run of cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      cnt   <= (sync[1] == stable || done) ? '0 : cnt + 1'b1;
      if (done) stable <= sync[1];
      pulse <= done && sync[1];
    end
  end
endmodule

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: code-breaking game controller with debounced buttons, LFSR secret and guess checking
module code_entry_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int MAX_TRIES = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_enter,
  input  logic [DIGIT_W-1:0] sw_digit,
  output logic startgame,
  output logic breakcode,
  output logic lose,
  output logic [$clog2(NUM_DIGITS+1)-1:0] hits,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries,
  output logic [NUM_DIGITS*DIGIT_W-1:0] secret
);
  localparam int HW = $clog2(NUM_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = NUM_DIGITS * DIGIT_W;
  state_t state, state_n;
  logic start_p, enter_p, last;
  logic [DIGIT_W-1:0] sw_m, sw_s;
  logic [LFSR_W-1:0] lfsr;
  logic [CW-1:0] guess, guess_n, secret_n;
  logic [IW-1:0] idx, idx_n;
  logic [HW-1:0] hits_n, match;
  logic [TW-1:0] tries_n;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .reset(reset), .btn(btn_start), .pulse(start_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .btn(btn_enter), .pulse(enter_p)
  );
  assign last = idx == IW'(NUM_DIGITS - 1);
  // free-running Galois LFSR and the switch synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
      sw_m <= sw_digit;
      sw_s <= sw_m;
    end
  end
  // count guess digits sitting in the same position as the secret's
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      match = match + HW'(guess[i*DIGIT_W +: DIGIT_W] == secret[i*DIGIT_W +: DIGIT_W]);
  end
  // next-state logic; a start pulse overrides everything else, including a coincident enter
  always_comb begin
    state_n  = state;
    secret_n = secret;
    tries_n  = tries;
    hits_n   = hits;
    idx_n    = idx;
    guess_n  = guess;
    if (state == ENTER && enter_p) begin
      guess_n[(NUM_DIGITS - 1 - int'(idx))*DIGIT_W +: DIGIT_W] = sw_s;
      idx_n   = last ? '0 : idx + 1'b1;
      state_n = last ? CHECK : ENTER;
    end
    if (state == CHECK) begin
      hits_n  = match;
      tries_n = (match == HW'(NUM_DIGITS) || tries == TW'(MAX_TRIES)) ? tries : tries + 1'b1;
      state_n = (match == HW'(NUM_DIGITS)) ? WIN : (tries_n == TW'(MAX_TRIES)) ? LOSE : ENTER;
    end
    if (start_p) begin
      state_n  = ENTER;
      secret_n = lfsr;
      tries_n  = '0;
      hits_n   = '0;
      idx_n    = '0;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      secret    <= '0;
      tries     <= '0;
      hits      <= '0;
      idx       <= '0;
      guess     <= '0;
      startgame <= 1'b0;
      breakcode <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= state_n;
      secret    <= secret_n;
      tries     <= tries_n;
      hits      <= hits_n;
      idx       <= idx_n;
      guess     <= guess_n;
      startgame <= state_n != IDLE;
      breakcode <= state_n == WIN;
      lose      <= state_n == LOSE;
    end
  end
endmodule
